// File: rtl/cyclic_encoder_serial.sv
// Serial systematic cyclic-code encoder: divides m(x)*x^R by g(x) in an LFSR and streams
// the codeword message-first, parity-after, while also presenting it in parallel.
module cyclic_encoder_serial #(
    parameter int unsigned     N   = 15,
    parameter int unsigned     K   = 7,
    parameter logic [N-K:0]    GEN = 9'b111010001
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [K-1:0] msg_in,
    input  logic         msg_valid,
    output logic         msg_ready,
    output logic         code_bit,
    output logic         code_valid,
    output logic         code_first,
    output logic         code_last,
    output logic [N-1:0] codeword,
    output logic         codeword_valid
);

    localparam int unsigned R  = N - K;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StMsg, StPar, StDone} state_t;

    state_t          state_q, state_d;
    logic [K-1:0]    msg_sr_q, msg_sr_d;
    logic [K-1:0]    msg_hold_q, msg_hold_d;
    logic [R-1:0]    par_q, par_d;
    logic [R-1:0]    par_hold_q, par_hold_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    codeword_q, codeword_d;
    logic            code_bit_q, code_bit_d;
    logic            code_valid_q, code_valid_d;
    logic            code_first_q, code_first_d;
    logic            code_last_q, code_last_d;
    logic            codeword_valid_q, codeword_valid_d;
    logic            msg_ready_q, msg_ready_d;
    logic            accept;
    logic            fb;

    always_comb begin
        state_d    = state_q;
        msg_sr_d   = msg_sr_q;
        msg_hold_d = msg_hold_q;
        par_d      = par_q;
        par_hold_d = par_hold_q;
        cnt_d      = cnt_q;
        codeword_d = codeword_q;
        accept     = 1'b0;
        fb         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (msg_valid && msg_ready_q) begin
                    accept     = 1'b1;
                    msg_sr_d   = msg_in;
                    msg_hold_d = msg_in;
                    par_d      = '0;
                    cnt_d      = '0;
                    state_d    = StMsg;
                end
            end
            StMsg: begin
                fb       = msg_sr_q[K-1] ^ par_q[R-1];
                par_d    = (par_q << 1) ^ (GEN[R-1:0] & {R{fb}});
                msg_sr_d = msg_sr_q << 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(K - 1)) begin
                    // Remainder is complete here; keep a copy since PAR shifts it out.
                    par_hold_d = par_d;
                    cnt_d      = '0;
                    state_d    = StPar;
                end
            end
            StPar: begin
                par_d = par_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(R - 1)) begin
                    codeword_d = {msg_hold_q, par_hold_q};
                    state_d    = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
    always_comb begin
        code_bit_d = 1'b0;
        unique case (state_d)
            StMsg:   code_bit_d = msg_sr_d[K-1];
            StPar:   code_bit_d = par_d[R-1];
            default: code_bit_d = 1'b0;
        endcase
        code_valid_d     = (state_d == StMsg) || (state_d == StPar);
        code_first_d     = accept;
        code_last_d      = (state_d == StPar) && (cnt_d == CW'(R - 1));
        codeword_valid_d = (state_d == StDone);
        msg_ready_d      = (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            msg_sr_q         <= '0;
            msg_hold_q       <= '0;
            par_q            <= '0;
            par_hold_q       <= '0;
            cnt_q            <= '0;
            codeword_q       <= '0;
            code_bit_q       <= 1'b0;
            code_valid_q     <= 1'b0;
            code_first_q     <= 1'b0;
            code_last_q      <= 1'b0;
            codeword_valid_q <= 1'b0;
            msg_ready_q      <= 1'b1;
        end else begin
            state_q          <= state_d;
            msg_sr_q         <= msg_sr_d;
            msg_hold_q       <= msg_hold_d;
            par_q            <= par_d;
            par_hold_q       <= par_hold_d;
            cnt_q            <= cnt_d;
            codeword_q       <= codeword_d;
            code_bit_q       <= code_bit_d;
            code_valid_q     <= code_valid_d;
            code_first_q     <= code_first_d;
            code_last_q      <= code_last_d;
            codeword_valid_q <= codeword_valid_d;
            msg_ready_q      <= msg_ready_d;
        end
    end

    assign msg_ready      = msg_ready_q;
    assign code_bit       = code_bit_q;
    assign code_valid     = code_valid_q;
    assign code_first     = code_first_q;
    assign code_last      = code_last_q;
    assign codeword       = codeword_q;
    assign codeword_valid = codeword_valid_q;

endmodule

// File: tb/tb_cyclic_encoder_serial.sv
// Directed bench for the (15,7) serial cyclic encoder: framing, codewords, busy, reset.
module tb_cyclic_encoder_serial;

    localparam int unsigned N = 15;
    localparam int unsigned K = 7;
    localparam logic [8:0]  G = 9'b111010001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [K-1:0]  msg_in = '0;
    logic          msg_valid = 1'b0;
    logic          msg_ready;
    logic          code_bit;
    logic          code_valid;
    logic          code_first;
    logic          code_last;
    logic [N-1:0]  codeword;
    logic          codeword_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cyclic_encoder_serial #(
        .N   (N),
        .K   (K),
        .GEN (G)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .msg_in         (msg_in),
        .msg_valid      (msg_valid),
        .msg_ready      (msg_ready),
        .code_bit       (code_bit),
        .code_valid     (code_valid),
        .code_first     (code_first),
        .code_last      (code_last),
        .codeword       (codeword),
        .codeword_valid (codeword_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Long division of a codeword by g(x); zero remainder means a valid codeword.
    function automatic logic [7:0] poly_rem(input logic [14:0] c);
        logic [14:0] r;
        logic [14:0] g15;
        r   = c;
        g15 = 15'(G);
        for (int i = 14; i >= 8; i--) begin
            if (r[i]) r = r ^ (g15 << (i - 8));
        end
        return r[7:0];
    endfunction

    // Sends one message and collects the serial stream, parallel codeword and framing slips.
    task automatic run_block(input logic [K-1:0] m, output logic [14:0] ser,
                             output logic [14:0] cw, output int frame_err);
        int t;
        t = 0;
        frame_err = 0;
        ser = '0;
        cw = '0;
        while (!msg_ready && t < 40) begin
            step();
            t++;
        end
        if (!msg_ready) frame_err++;
        msg_in = m;
        msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            ser[15-c] = code_bit;
            if (code_valid !== 1'b1 || code_first !== (c == 1) || code_last !== (c == 15) ||
                msg_ready !== 1'b0 || codeword_valid !== 1'b0) frame_err++;
            step();
        end
        cw = codeword;
        if (codeword_valid !== 1'b1 || code_valid !== 1'b0 || msg_ready !== 1'b0) frame_err++;
        step();
        if (codeword_valid !== 1'b0 || msg_ready !== 1'b1 || codeword !== cw) frame_err++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (msg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_msg_ready got %b want 1", msg_ready);
        end
        checks++;
        if ({code_bit, code_valid, code_first, code_last} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_stream got %b want 0000",
                     {code_bit, code_valid, code_first, code_last});
        end
        checks++;
        if (codeword !== 15'h0000 || codeword_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_codeword got %h/%b want 0000/0", codeword, codeword_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_generator();
        logic [14:0] ser, cw;
        int fe;
        run_block(7'b0000001, ser, cw, fe);
        checks++;
        if (ser !== 15'b000000111010001) begin
            errors++;
            $display("FAIL gen_serial got %b want 000000111010001", ser);
        end
        checks++;
        if (cw !== 15'h01D1) begin
            errors++;
            $display("FAIL gen_codeword got %h want 01d1", cw);
        end
        checks++;
        if (fe !== 0) begin
            errors++;
            $display("FAIL gen_framing got %0d slips want 0", fe);
        end
    endtask

    task automatic test_patterns();
        logic [14:0] ser, cw;
        int fe;
        logic [K-1:0] msgs [3];
        logic [14:0]  exps [3];
        msgs = '{7'b0000011, 7'b0000000, 7'h7F};
        exps = '{15'h03A2, 15'h0000, 15'h7FFF};
        for (int i = 0; i < 3; i++) begin
            run_block(msgs[i], ser, cw, fe);
            checks++;
            if (cw !== exps[i]) begin
                errors++;
                $display("FAIL pattern_codeword msg=%h got %h want %h", msgs[i], cw, exps[i]);
            end
            checks++;
            if (ser !== exps[i]) begin
                errors++;
                $display("FAIL pattern_serial msg=%h got %h want %h", msgs[i], ser, exps[i]);
            end
            checks++;
            if (fe !== 0) begin
                errors++;
                $display("FAIL pattern_framing msg=%h got %0d slips want 0", msgs[i], fe);
            end
        end
    endtask

    task automatic test_random();
        logic [14:0] ser, cw;
        logic [K-1:0] m;
        int fe;
        for (int i = 0; i < 200; i++) begin
            m = K'($urandom_range(0, 127));
            run_block(m, ser, cw, fe);
            checks++;
            if (poly_rem(cw) !== 8'h00 || cw[14:8] !== m) begin
                errors++;
                $display("FAIL random_codeword msg=%h got %h rem=%h want rem 00", m, cw,
                         poly_rem(cw));
            end
            checks++;
            if (ser !== cw || fe !== 0) begin
                errors++;
                $display("FAIL random_serial msg=%h got %h slips=%0d want %h slips=0",
                         m, ser, fe, cw);
            end
        end
    endtask

    task automatic test_busy();
        msg_in = 7'b0000011;
        msg_valid = 1'b1;
        step();
        msg_in = 7'h55;
        repeat (15) step();
        msg_valid = 1'b0;
        checks++;
        if (codeword !== 15'h03A2 || codeword_valid !== 1'b1) begin
            errors++;
            $display("FAIL busy_codeword got %h/%b want 03a2/1", codeword, codeword_valid);
        end
        step();
        checks++;
        if (msg_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_ready got %b want 1", msg_ready);
        end
        repeat (4) step();
        checks++;
        if (code_valid !== 1'b0 || codeword !== 15'h03A2) begin
            errors++;
            $display("FAIL busy_ignored got valid=%b cw=%h want valid=0 cw=03a2",
                     code_valid, codeword);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp_cw;
        int firsts;
        int slips;
        int t;
        int p;
        exp_cw = 15'h01D1;
        firsts = 0;
        slips = 0;
        msg_in = 7'b0000001;
        msg_valid = 1'b1;
        step();
        for (int i = 0; i < 51; i++) begin
            p = i % 17;
            if (code_first === 1'b1) firsts++;
            if (code_valid !== (p < 15) || code_first !== (p == 0) ||
                code_last !== (p == 14) || codeword_valid !== (p == 15) ||
                msg_ready !== (p == 16)) slips++;
            if (p < 15 && code_bit !== exp_cw[14-p]) slips++;
            step();
        end
        msg_valid = 1'b0;
        checks++;
        if (firsts !== 3) begin
            errors++;
            $display("FAIL b2b_blocks got %0d want 3", firsts);
        end
        checks++;
        if (slips !== 0) begin
            errors++;
            $display("FAIL b2b_stream got %0d slips want 0", slips);
        end
        t = 0;
        while (!msg_ready && t < 40) begin
            step();
            t++;
        end
        checks++;
        if (msg_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain got ready=%b want 1", msg_ready);
        end
    endtask

    task automatic test_reset_mid_block();
        logic [14:0] ser, cw;
        int fe;
        msg_in = 7'h7F;
        msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
        repeat (4) step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (code_valid !== 1'b0 || code_bit !== 1'b0 || msg_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_async got valid=%b bit=%b ready=%b want 0 0 1",
                     code_valid, code_bit, msg_ready);
        end
        checks++;
        if (codeword !== 15'h0000 || codeword_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_codeword got %h/%b want 0000/0", codeword, codeword_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        run_block(7'b0000001, ser, cw, fe);
        checks++;
        if (cw !== 15'h01D1 || ser !== 15'h01D1 || fe !== 0) begin
            errors++;
            $display("FAIL midreset_recover got cw=%h ser=%h slips=%0d want 01d1 01d1 0",
                     cw, ser, fe);
        end
    endtask

    initial begin
        test_reset();
        test_generator();
        test_patterns();
        test_random();
        test_busy();
        test_back_to_back();
        test_reset_mid_block();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
